spi_rx_deser: RTL and testbench
===============================

# spi_rx_deser

SPI receive deserializer: the downstream stage of the SPI master core. It consumes the master's SCK/CS/MOSI lines, oversamples them in the `clk_100` domain, and reassembles MSB-first words of `P_DATA_WIDTH` bits. It presents each completed word on a valid/ready output with overrun and framing-error reporting. Used as an in-system loopback checker and as the receive front-end of peripheral models.

## Interface
Parameters:
- `P_DATA_WIDTH`, 8: bits per word; must be ≥ 2.
- `P_CS_POLAR`, 1: active level of CS (1 = active-high).
- `P_CPOL`, 0: SCK idle level. Sampling edge is rising when `P_CPOL`=0 and falling when `P_CPOL`=1.

Ports:
- `clk_100` in 1: system clock.
- `a_rst` in 1: reset, asynchronous, active-high.
- `SCK` in 1: serial clock from the master; asynchronous to `clk_100`.
- `CS` in 1: chip select from the master; asynchronous.
- `MOSI` in 1: serial data from the master; asynchronous.
- `rx_data` out `P_DATA_WIDTH`: received word; valid while `rx_valid`=1.
- `rx_valid` out 1: word available.
- `rx_ready` in 1: consumer accepts the word when `rx_valid && rx_ready`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `frame_err` out 1: one-cycle pulse when CS deasserts mid-word.
- `busy` out 1: high while in RECV.

## Operation
- **Synchronization:** SCK, CS and MOSI each pass through a 2-flop synchronizer. A third SCK register provides edge detection. Synchronizer reset values are `P_CPOL`, `!P_CS_POLAR` and 0, so no spurious edge appears after reset.
- **State machine** (reset state WAIT_IDLE):
  - WAIT_IDLE → IDLE when synchronized CS is inactive. This guarantees that a frame already in progress at reset release is ignored.
  - IDLE → RECV when synchronized CS is active. The bit counter and shift register are cleared on entry.
  - RECV:
    - On each synchronized sampling edge, shift the synchronized MOSI in at the LSB and increment the bit counter.
    - When the counter reaches `P_DATA_WIDTH`, the word completes and the counter wraps to 0. The state stays RECV, so multiple words per CS frame are allowed.
  - RECV → IDLE when CS goes inactive. If the bit counter ≠ 0, pulse `frame_err` and discard the partial word. Edges seen on the same cycle as CS deassertion are ignored.
- **Output register (single entry):**
  - Word completes and (`!rx_valid` or `rx_ready`): load `rx_data`, set `rx_valid`. Simultaneous accept-and-load produces no overrun.
  - Word completes while `rx_valid && !rx_ready`: drop the new word, pulse `overrun`. `rx_data` keeps the old word.
  - `rx_valid && rx_ready` with no completion: clear `rx_valid`. `rx_data` holds its last value.
- **Counter width:** `$clog2(P_DATA_WIDTH+1)` bits, compared against `P_DATA_WIDTH`.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `overrun`=0, `frame_err`=0, `busy`=0. State is WAIT_IDLE, counter and shift register are 0.
- **Input constraint:** SCK high and low phases each ≥ 3 `clk_100` cycles. MOSI must be stable ≥ 3 cycles before and 1 cycle after the sampling edge. CS setup before the first sampling edge ≥ 3 cycles. Faster SCK is outside spec.
- **Cycle numbering:** cycle 0 is the first `clk_100` edge that captures a new SCK level in sync stage 1.
  - Edge detect fires at cycle 2.
  - The shift happens at cycle 2 and, for the final bit, `rx_valid` and `rx_data` are registered at cycle 3.
- **Framing error:** the `frame_err` pulse appears 3 cycles after CS deassertion is first captured. `busy` falls on the same cycle.
- `overrun` and `frame_err` are each one cycle wide, registered, and never asserted during reset.
- **Reset mid-word:** all state is lost and no output fires. The next word is accepted only after CS is seen inactive and then re-asserted.

## Structure
- Shared package `spi_pkg` holds:
  - the `spi_rx_state_t` enum (WAIT_IDLE, IDLE, RECV);
  - a width helper function for the bit counter.
- One sub-module, `spi_sync`: a 2-flop synchronizer with a parameterised reset value. It is instantiated three times.

## Test plan
1. **Reset with active frame:** assert `a_rst` with CS active and SCK toggling, then release mid-frame → all outputs 0, no `rx_valid` until CS deasserts and re-asserts. A following byte 0xA5 is received correctly.
2. **Single byte:** 0xA5 with SCK period 8 cycles and `rx_ready`=1 → `rx_valid` high for exactly one cycle with `rx_data`=0xA5, 3 cycles after the 8th rising edge is captured. `busy` is high during the frame.
3. **Overrun:** 0x3C then 0xC3 in one CS frame with `rx_ready`=0 → `rx_valid` held with 0x3C, one `overrun` pulse at the second completion, `rx_data` stays 0x3C. Raising `rx_ready` clears `rx_valid` next cycle.
4. **Framing error:** CS deasserted after 5 bits → one `frame_err` pulse, no `rx_valid`. The next frame 0x81 is received correctly with no error.
5. **Simultaneous accept and load:** 0x11 pending; `rx_ready`=1 on the exact cycle 0x22 completes → no `overrun`, `rx_data`=0x22 and `rx_valid`=1 on the next cycle.
6. **CPOL=1 variant:** `P_CPOL`=1 with idle-high SCK, byte 0x5A sampled on falling edges → `rx_data`=0x5A. No spurious edge after reset release.

Source files
------------

// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI receive deserializer:
//   spi_rx_state_t : receiver FSM states
//   spi_cnt_width  : bit-counter width able to hold the value data_width
// ----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      RECV      = 2'd2
   } spi_rx_state_t;

   function automatic int spi_cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/spi_rx_deser_if.sv
// ----------------------------------------------------------------------------
// spi_rx_deser_if
// Bundles the SPI lines and the received-word handshake of spi_rx_deser.
//   SCK, CS, MOSI         : serial lines from the SPI master (asynchronous)
//   rx_data, rx_valid     : received word and its valid flag
//   rx_ready              : consumer accepts on rx_valid && rx_ready
//   overrun, frame_err    : one-cycle error pulses
//   busy                  : receiver is inside a frame
// Modports: slave = deserializer side, master = line driver / consumer side.
// ----------------------------------------------------------------------------
interface spi_rx_deser_if #(
   parameter int P_DATA_WIDTH = 8
);
   logic                    SCK;
   logic                    CS;
   logic                    MOSI;
   logic [P_DATA_WIDTH-1:0] rx_data;
   logic                    rx_valid;
   logic                    rx_ready;
   logic                    overrun;
   logic                    frame_err;
   logic                    busy;

   modport slave (
      input  SCK, CS, MOSI, rx_ready,
      output rx_data, rx_valid, overrun, frame_err, busy
   );

   modport master (
      output SCK, CS, MOSI, rx_ready,
      input  rx_data, rx_valid, overrun, frame_err, busy
   );
endinterface

// File: rtl/spi_sync.sv
// ----------------------------------------------------------------------------
// spi_sync
// Two-flop synchronizer with a parameterised reset value.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
// ----------------------------------------------------------------------------
module spi_sync #(
   parameter logic P_RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= P_RST_VAL;
         sync_q <= P_RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/spi_rx_deser.sv
// ----------------------------------------------------------------------------
// spi_rx_deser
// SPI receive deserializer. Oversamples SCK/CS/MOSI in the clk_100 domain,
// assembles MSB-first words of P_DATA_WIDTH bits and offers them on a
// single-entry valid/ready register with overrun and framing-error pulses.
//   clk_100 : system clock
//   a_rst   : asynchronous active-high reset
//   bus     : spi_rx_deser_if slave (SCK, CS, MOSI in; rx_data, rx_valid,
//             overrun, frame_err, busy out; rx_ready in)
// ----------------------------------------------------------------------------
module spi_rx_deser
   import spi_pkg::*;
#(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_CS_POLAR   = 1,
   parameter int P_CPOL       = 0
) (
   input  logic           clk_100,
   input  logic           a_rst,
   spi_rx_deser_if.slave  bus
);
   localparam int               CNT_W    = spi_cnt_width(P_DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(P_DATA_WIDTH);
   localparam logic             CS_ACT   = (P_CS_POLAR != 0);
   localparam logic             SCK_IDLE = (P_CPOL != 0);

   logic sck_s, cs_s, mosi_s;

   spi_sync #(.P_RST_VAL(SCK_IDLE)) u_sync_sck (
      .clk_i(clk_100), .rst_i(a_rst), .d_i(bus.SCK),  .q_o(sck_s)
   );
   spi_sync #(.P_RST_VAL(!CS_ACT))  u_sync_cs (
      .clk_i(clk_100), .rst_i(a_rst), .d_i(bus.CS),   .q_o(cs_s)
   );
   spi_sync #(.P_RST_VAL(1'b0))     u_sync_mosi (
      .clk_i(clk_100), .rst_i(a_rst), .d_i(bus.MOSI), .q_o(mosi_s)
   );

   spi_rx_state_t           state_q, state_d;
   logic                    sck_q, sck_d;
   logic [1:0]              settle_q, settle_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
   logic [P_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    overrun_q, overrun_d;
   logic                    frame_err_q, frame_err_d;
   logic                    busy_q, busy_d;

   logic cs_act, samp_edge, word_done;

   always_comb begin
      cs_act    = (cs_s == CS_ACT);
      samp_edge = (sck_s != sck_q) && (sck_s == !SCK_IDLE);
      word_done = (cnt_q == CNT_FULL);

      state_d     = state_q;
      sck_d       = sck_s;
      // The synchronizers still hold reset values for two cycles after
      // reset; CS is not trusted until they have been refilled.
      settle_d    = {settle_q[0], 1'b1};
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = 1'b0;
      busy_d      = (state_q == RECV);

      if (word_done) begin
         cnt_d = '0;
      end

      unique case (state_q)
         WAIT_IDLE: begin
            if (settle_q[1] && !cs_act) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (cs_act) begin
               state_d = RECV;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         RECV: begin
            // CS loss wins over a coincident sampling edge.
            if (!cs_act) begin
               state_d = IDLE;
            end else if (samp_edge) begin
               shift_d = {shift_q[P_DATA_WIDTH-2:0], mosi_s};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase

      // busy_q still reflects RECV for the cycle after leaving it, so this
      // fires once, together with busy falling.
      frame_err_d = busy_q && (state_q != RECV) && (cnt_q != '0) && !word_done;

      if (word_done) begin
         if (!rx_valid_q || bus.rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d  = 1'b1;
         end
      end else if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_100 or posedge a_rst) begin
      if (a_rst) begin
         state_q     <= WAIT_IDLE;
         sck_q       <= SCK_IDLE;
         settle_q    <= '0;
         cnt_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_q       <= sck_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_rx_deser.sv
// ----------------------------------------------------------------------------
// tb_spi_rx_deser
// Self-checking bench for spi_rx_deser. dut0 runs CPOL=0, dut1 runs CPOL=1
// and sees the inverted SCK. Received words are scored against queues of
// expected words filled when the frames are driven.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_rx_deser;
   logic clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   logic a_rst = 1'b1;
   logic sck   = 1'b0;
   logic mosi  = 1'b0;
   logic cs0   = 1'b0;
   logic cs1   = 1'b0;
   logic rdy0  = 1'b1;
   logic rdy1  = 1'b1;

   int checks   = 0;
   int failures = 0;
   int v0_cnt   = 0;
   int v1_cnt   = 0;
   int ovr0_cnt = 0;
   int ovr1_cnt = 0;
   int fe0_cnt  = 0;
   int fe1_cnt  = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] exp0, exp1;

   spi_rx_deser_if #(.P_DATA_WIDTH(8)) bus0();
   spi_rx_deser_if #(.P_DATA_WIDTH(8)) bus1();

   assign bus0.SCK      = sck;
   assign bus0.CS       = cs0;
   assign bus0.MOSI     = mosi;
   assign bus0.rx_ready = rdy0;
   assign bus1.SCK      = ~sck;
   assign bus1.CS       = cs1;
   assign bus1.MOSI     = mosi;
   assign bus1.rx_ready = rdy1;

   spi_rx_deser #(.P_DATA_WIDTH(8), .P_CS_POLAR(1), .P_CPOL(0)) dut0 (
      .clk_100(clk_100), .a_rst(a_rst), .bus(bus0)
   );
   spi_rx_deser #(.P_DATA_WIDTH(8), .P_CS_POLAR(1), .P_CPOL(1)) dut1 (
      .clk_100(clk_100), .a_rst(a_rst), .bus(bus1)
   );

   // Scoreboard and pulse counters, sampled mid-cycle.
   always @(negedge clk_100) begin
      if (bus0.rx_valid)  v0_cnt++;
      if (bus1.rx_valid)  v1_cnt++;
      if (bus0.overrun)   ovr0_cnt++;
      if (bus1.overrun)   ovr1_cnt++;
      if (bus0.frame_err) fe0_cnt++;
      if (bus1.frame_err) fe1_cnt++;
      if (bus0.rx_valid && bus0.rx_ready) begin
         checks++;
         if (q0.size() == 0) begin
            $display("FAIL sb0_unexpected got=%h expected=none", bus0.rx_data);
            failures++;
         end else begin
            exp0 = q0.pop_front();
            if (bus0.rx_data !== exp0) begin
               $display("FAIL sb0_data got=%h expected=%h", bus0.rx_data, exp0);
               failures++;
            end
         end
      end
      if (bus1.rx_valid && bus1.rx_ready) begin
         checks++;
         if (q1.size() == 0) begin
            $display("FAIL sb1_unexpected got=%h expected=none", bus1.rx_data);
            failures++;
         end else begin
            exp1 = q1.pop_front();
            if (bus1.rx_data !== exp1) begin
               $display("FAIL sb1_data got=%h expected=%h", bus1.rx_data, exp1);
               failures++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   // One bit, SCK period 8 cycles; rising edge of sck samples.
   task automatic send_bit(input logic b);
      mosi = b;
      repeat (4) tick();
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
   endtask

   task automatic test_reset();
      int vb, fb;
      a_rst = 1'b1; cs0 = 1'b1; rdy0 = 1'b1;
      send_bit(1'b1);
      send_bit(1'b0);
      checks++; if (bus0.rx_valid !== 1'b0)  begin $display("FAIL rst_valid got=%b expected=0", bus0.rx_valid); failures++; end
      checks++; if (bus0.rx_data !== 8'h00)  begin $display("FAIL rst_data got=%h expected=00", bus0.rx_data); failures++; end
      checks++; if (bus0.overrun !== 1'b0)   begin $display("FAIL rst_overrun got=%b expected=0", bus0.overrun); failures++; end
      checks++; if (bus0.frame_err !== 1'b0) begin $display("FAIL rst_frame_err got=%b expected=0", bus0.frame_err); failures++; end
      checks++; if (bus0.busy !== 1'b0)      begin $display("FAIL rst_busy got=%b expected=0", bus0.busy); failures++; end
      vb = v0_cnt; fb = fe0_cnt;
      a_rst = 1'b0;
      send_word(8'hFF, 8);
      send_word(8'h05, 3);
      checks++; if (v0_cnt !== vb) begin $display("FAIL rst_midframe_valid got=%0d expected=%0d", v0_cnt, vb); failures++; end
      checks++; if (bus0.busy !== 1'b0) begin $display("FAIL rst_midframe_busy got=%b expected=0", bus0.busy); failures++; end
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (fe0_cnt !== fb) begin $display("FAIL rst_midframe_ferr got=%0d expected=%0d", fe0_cnt, fb); failures++; end
      cs0 = 1'b1;
      repeat (4) tick();
      q0.push_back(8'hA5);
      send_word(8'hA5, 8);
      repeat (4) tick();
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (q0.size() != 0) begin $display("FAIL rst_after_word got=%0d_pending expected=0", q0.size()); failures++; end
   endtask

   task automatic test_single_byte();
      int vb;
      rdy0 = 1'b1; vb = v0_cnt;
      cs0 = 1'b1;
      repeat (4) tick();
      q0.push_back(8'hA5);
      send_word(8'h52, 7);
      checks++; if (bus0.busy !== 1'b1) begin $display("FAIL single_busy got=%b expected=1", bus0.busy); failures++; end
      mosi = 1'b1;
      repeat (4) tick();
      sck = 1'b1;
      repeat (3) tick();
      checks++; if (bus0.rx_valid !== 1'b0) begin $display("FAIL single_early_valid got=%b expected=0", bus0.rx_valid); failures++; end
      tick();
      checks++; if (bus0.rx_valid !== 1'b1) begin $display("FAIL single_valid got=%b expected=1", bus0.rx_valid); failures++; end
      checks++; if (bus0.rx_data !== 8'hA5) begin $display("FAIL single_data got=%h expected=a5", bus0.rx_data); failures++; end
      tick();
      checks++; if (bus0.rx_valid !== 1'b0) begin $display("FAIL single_valid_drop got=%b expected=0", bus0.rx_valid); failures++; end
      repeat (3) tick();
      sck = 1'b0;
      repeat (4) tick();
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (v0_cnt !== vb + 1) begin $display("FAIL single_valid_cycles got=%0d expected=%0d", v0_cnt - vb, 1); failures++; end
      checks++; if (q0.size() != 0) begin $display("FAIL single_pending got=%0d expected=0", q0.size()); failures++; end
   endtask

   task automatic test_overrun();
      int ob, fb;
      ob = ovr0_cnt; fb = fe0_cnt;
      rdy0 = 1'b0;
      cs0 = 1'b1;
      repeat (4) tick();
      q0.push_back(8'h3C);
      send_word(8'h3C, 8);
      send_word(8'hC3, 8);
      repeat (6) tick();
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (ovr0_cnt !== ob + 1) begin $display("FAIL ovr_pulses got=%0d expected=%0d", ovr0_cnt - ob, 1); failures++; end
      checks++; if (bus0.rx_valid !== 1'b1) begin $display("FAIL ovr_valid_held got=%b expected=1", bus0.rx_valid); failures++; end
      checks++; if (bus0.rx_data !== 8'h3C) begin $display("FAIL ovr_data_kept got=%h expected=3c", bus0.rx_data); failures++; end
      checks++; if (fe0_cnt !== fb) begin $display("FAIL ovr_no_ferr got=%0d expected=%0d", fe0_cnt, fb); failures++; end
      rdy0 = 1'b1;
      tick();
      checks++; if (bus0.rx_valid !== 1'b0) begin $display("FAIL ovr_accept_clear got=%b expected=0", bus0.rx_valid); failures++; end
      repeat (2) tick();
      checks++; if (q0.size() != 0) begin $display("FAIL ovr_pending got=%0d expected=0", q0.size()); failures++; end
   endtask

   task automatic test_frame_err();
      int fb, vb;
      fb = fe0_cnt; vb = v0_cnt;
      rdy0 = 1'b1;
      cs0 = 1'b1;
      repeat (4) tick();
      send_word(8'h16, 5);
      cs0 = 1'b0;
      repeat (3) tick();
      checks++; if (bus0.frame_err !== 1'b0) begin $display("FAIL ferr_early got=%b expected=0", bus0.frame_err); failures++; end
      checks++; if (bus0.busy !== 1'b1)      begin $display("FAIL ferr_busy_early got=%b expected=1", bus0.busy); failures++; end
      tick();
      checks++; if (bus0.frame_err !== 1'b1) begin $display("FAIL ferr_pulse got=%b expected=1", bus0.frame_err); failures++; end
      checks++; if (bus0.busy !== 1'b0)      begin $display("FAIL ferr_busy_fall got=%b expected=0", bus0.busy); failures++; end
      repeat (6) tick();
      checks++; if (fe0_cnt !== fb + 1) begin $display("FAIL ferr_count got=%0d expected=%0d", fe0_cnt - fb, 1); failures++; end
      checks++; if (v0_cnt !== vb) begin $display("FAIL ferr_no_valid got=%0d expected=%0d", v0_cnt, vb); failures++; end
      cs0 = 1'b1;
      repeat (4) tick();
      q0.push_back(8'h81);
      send_word(8'h81, 8);
      repeat (4) tick();
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (q0.size() != 0) begin $display("FAIL ferr_next_pending got=%0d expected=0", q0.size()); failures++; end
      checks++; if (fe0_cnt !== fb + 1) begin $display("FAIL ferr_next_clean got=%0d expected=%0d", fe0_cnt - fb, 1); failures++; end
   endtask

   task automatic test_back_to_back();
      int ob;
      ob = ovr0_cnt;
      rdy0 = 1'b0;
      cs0 = 1'b1;
      repeat (4) tick();
      q0.push_back(8'h11);
      q0.push_back(8'h22);
      send_word(8'h11, 8);
      send_word(8'h11, 7);
      mosi = 1'b0;
      repeat (4) tick();
      sck = 1'b1;
      repeat (3) tick();
      rdy0 = 1'b1;
      tick();
      checks++; if (bus0.rx_valid !== 1'b1) begin $display("FAIL b2b_valid got=%b expected=1", bus0.rx_valid); failures++; end
      checks++; if (bus0.rx_data !== 8'h22) begin $display("FAIL b2b_data got=%h expected=22", bus0.rx_data); failures++; end
      checks++; if (ovr0_cnt !== ob) begin $display("FAIL b2b_no_overrun got=%0d expected=%0d", ovr0_cnt - ob, 0); failures++; end
      tick();
      checks++; if (bus0.rx_valid !== 1'b0) begin $display("FAIL b2b_valid_drop got=%b expected=0", bus0.rx_valid); failures++; end
      repeat (2) tick();
      sck = 1'b0;
      repeat (4) tick();
      cs0 = 1'b0;
      repeat (8) tick();
      checks++; if (q0.size() != 0) begin $display("FAIL b2b_pending got=%0d expected=0", q0.size()); failures++; end
   endtask

   task automatic test_cpol1();
      int vb;
      a_rst = 1'b1; cs0 = 1'b0; cs1 = 1'b0; sck = 1'b0; rdy1 = 1'b1;
      repeat (3) tick();
      a_rst = 1'b0;
      checks++; if (bus0.rx_data !== 8'h00) begin $display("FAIL cpol1_rst_data0 got=%h expected=00", bus0.rx_data); failures++; end
      vb = v1_cnt;
      repeat (8) tick();
      checks++; if (v1_cnt !== vb) begin $display("FAIL cpol1_spurious got=%0d expected=%0d", v1_cnt, vb); failures++; end
      checks++; if (bus1.busy !== 1'b0) begin $display("FAIL cpol1_idle_busy got=%b expected=0", bus1.busy); failures++; end
      cs1 = 1'b1;
      repeat (4) tick();
      q1.push_back(8'h5A);
      send_word(8'h5A, 8);
      repeat (4) tick();
      cs1 = 1'b0;
      repeat (8) tick();
      checks++; if (q1.size() != 0) begin $display("FAIL cpol1_pending got=%0d expected=0", q1.size()); failures++; end
      checks++; if (v1_cnt !== vb + 1) begin $display("FAIL cpol1_words got=%0d expected=%0d", v1_cnt - vb, 1); failures++; end
      checks++; if (fe1_cnt !== 0 || ovr1_cnt !== 0) begin $display("FAIL cpol1_errors got=%0d/%0d expected=0/0", fe1_cnt, ovr1_cnt); failures++; end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_overrun();
      test_frame_err();
      test_back_to_back();
      test_cpol1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
